// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame shape and the
// clock-divider arithmetic used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per serial bit, truncating so both ends agree exactly.
    function automatic int calc_divider(input int hz, input int baudrate);
        return hz / baudrate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like an edge after reset.
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Each stage simply takes the value of the stage before it.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchronizer chain, forced to the line's idle level on reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Qualifies the start bit at its centre, samples
// every data bit at its centre, checks the stop bit and reports either a
// one-cycle valid strobe with the byte or a one-cycle framing-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUDRATE = 56600,
    parameter int HZ       = 100_000_000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_signal,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    localparam int DIVIDER       = calc_divider(HZ, BAUDRATE);
    localparam int HALF          = DIVIDER / 2;
    localparam int COUNTER_WIDTH = $clog2(DIVIDER);
    localparam int CNT_W         = COUNTER_WIDTH + 1;
    // Index is sized to span every data and stop slot of a frame.
    localparam int IDX_W         = $clog2(DATA_BITS + STOP_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST     = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(DIVIDER - 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_d_q;
    logic                 rx_d_d;
    uart_state_t          state_q;
    uart_state_t          state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 ferr_q;
    logic                 ferr_d;
    logic                 busy_q;
    logic                 busy_d;

    uart_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_signal),
        .o_sync    (rx_s)
    );

    // Next-state logic: bit timing, sampling, shifting and the output strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        rx_d_d  = rx_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA_IDX) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers, all cleared to an idle receiver on reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_d_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_d_q  <= rx_d_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 16 clocks per bit. The bench acts as the serial
// transmitter and keeps an event-level model: every frame it sends predicts
// either a valid byte or a framing error, which is compared with what the
// receiver reports.
module tb_uart_rx;

    localparam int TB_HZ       = 16;
    localparam int TB_BAUD     = 1;
    localparam int BIT_CYCLES  = TB_HZ / TB_BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int LATENCY     = HALF_CYCLES + 9 * BIT_CYCLES + 3;
    localparam int BUSY_FRAME  = HALF_CYCLES + 9 * BIT_CYCLES;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;
    logic       rx_busy;

    int cycle = 0;
    int checks = 0;
    int failures = 0;

    int   valid_count = 0;
    int   error_count = 0;
    int   both_count = 0;
    int   busy_count = 0;
    int   busy_fall_cycle = 0;
    int   edge_cycle = 0;
    int   high_cycle = 0;
    logic busy_prev = 1'b0;

    int         valid_cycles[$];
    logic       obs_kind[$];
    logic [7:0] obs_data[$];
    logic       exp_kind[$];
    logic [7:0] exp_data[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .BAUDRATE (TB_BAUD),
        .HZ       (TB_HZ)
    ) dut (
        .i_clock       (clock),
        .i_reset_n     (reset_n),
        .i_signal      (serial_line),
        .o_data        (rx_data),
        .o_valid       (rx_valid),
        .o_frame_error (rx_frame_error),
        .o_busy        (rx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Record every strobe and the busy profile, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_valid) begin
                valid_count++;
                valid_cycles.push_back(cycle);
                obs_kind.push_back(1'b0);
                obs_data.push_back(rx_data);
            end
            if (rx_frame_error) begin
                error_count++;
                obs_kind.push_back(1'b1);
                obs_data.push_back(rx_data);
            end
            if (rx_valid && rx_frame_error) both_count++;
            if (rx_busy) busy_count++;
            if (busy_prev && !rx_busy) busy_fall_cycle = cycle;
            busy_prev = rx_busy;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendLevel(input logic level, input int n);
        serial_line = level;
        repeat (n) @(negedge clock);
    endtask

    // Send one frame and record what a correct receiver must report for it.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_ok,
                                 input int stop_cycles, input int gap);
        edge_cycle = cycle;
        sendLevel(1'b0, BIT_CYCLES);
        for (int i = 0; i < 8; i++) sendLevel(value[i], BIT_CYCLES);
        sendLevel(stop_ok, stop_cycles);
        high_cycle = cycle;
        if (stop_ok) begin
            exp_kind.push_back(1'b0);
            exp_data.push_back(value);
            last_good = value;
        end else begin
            exp_kind.push_back(1'b1);
            exp_data.push_back(last_good);
        end
        sendLevel(1'b1, gap);
    endtask

    task automatic clearMonitor();
        @(posedge clock);
        valid_count = 0;
        error_count = 0;
        busy_count  = 0;
        valid_cycles.delete();
        obs_kind.delete();
        obs_data.delete();
        exp_kind.delete();
        exp_data.delete();
        @(negedge clock);
    endtask

    task automatic compareEvents(input string prefix);
        int n;
        checkOutput({prefix, "_event_count"}, 32'(obs_kind.size()), 32'(exp_kind.size()));
        n = (obs_kind.size() < exp_kind.size()) ? obs_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_ev%0d_kind", prefix, i), 32'(obs_kind[i]), 32'(exp_kind[i]));
            checkOutput($sformatf("%s_ev%0d_data", prefix, i), 32'(obs_data[i]), 32'(exp_data[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int lat;
        int spacing;
        logic [7:0] abort_byte;
        logic [7:0] fixed_bytes [4];
        logic [7:0] rnd;
        logic       good;

        // Reset state, before the first clock edge has even occurred.
        #2;
        checkOutput("reset_data", 32'(rx_data), 32'h0);
        checkOutput("reset_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset_ferr", 32'(rx_frame_error), 32'h0);
        checkOutput("reset_busy", 32'(rx_busy), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Single good frame 0xA5.
        clearMonitor();
        applyStimulus(8'hA5, 1'b1, BIT_CYCLES, 20);
        compareEvents("a5");
        checkOutput("a5_valid_count", 32'(valid_count), 32'd1);
        checkOutput("a5_error_count", 32'(error_count), 32'd0);
        checkOutput("a5_data", 32'(rx_data), 32'hA5);
        lat = (valid_cycles.size() > 0) ? valid_cycles[0] - edge_cycle : -1;
        checkOutput("a5_latency_in_range", 32'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 32'd1);
        checkOutput("a5_busy_cycles_in_range",
                    32'(busy_count >= BUSY_FRAME - 1 && busy_count <= BUSY_FRAME + 1), 32'd1);

        // Start glitch of 3 cycles must be rejected.
        clearMonitor();
        sendLevel(1'b0, 3);
        sendLevel(1'b1, 30);
        checkOutput("glitch_valid_count", 32'(valid_count), 32'd0);
        checkOutput("glitch_error_count", 32'(error_count), 32'd0);
        checkOutput("glitch_busy_bounded", 32'(busy_count >= 1 && busy_count <= HALF_CYCLES), 32'd1);
        checkOutput("glitch_busy_end", 32'(rx_busy), 32'd0);

        // 0x3C with a low stop bit and a 40-cycle break.
        clearMonitor();
        applyStimulus(8'h3C, 1'b0, 40, 30);
        compareEvents("break");
        checkOutput("break_error_count", 32'(error_count), 32'd1);
        checkOutput("break_valid_count", 32'(valid_count), 32'd0);
        checkOutput("break_data_held", 32'(rx_data), 32'hA5);
        checkOutput("break_busy_release",
                    32'(busy_fall_cycle - high_cycle >= 2 && busy_fall_cycle - high_cycle <= 4), 32'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        clearMonitor();
        applyStimulus(8'h00, 1'b1, BIT_CYCLES, 0);
        applyStimulus(8'hFF, 1'b1, BIT_CYCLES, 20);
        compareEvents("b2b");
        checkOutput("b2b_valid_count", 32'(valid_count), 32'd2);
        spacing = (valid_cycles.size() == 2) ? valid_cycles[1] - valid_cycles[0] : -1;
        checkOutput("b2b_spacing", 32'(spacing), 32'd160);

        // Reset in the middle of data bit 4 of 0x81, then a clean 0x42.
        clearMonitor();
        abort_byte = 8'h81;
        sendLevel(1'b0, BIT_CYCLES);
        for (int i = 0; i < 4; i++) sendLevel(abort_byte[i], BIT_CYCLES);
        sendLevel(abort_byte[4], HALF_CYCLES);
        reset_n = 1'b0;
        serial_line = 1'b1;
        last_good = 8'h00;
        #2;
        checkOutput("midreset_data", 32'(rx_data), 32'h0);
        checkOutput("midreset_valid", 32'(rx_valid), 32'h0);
        checkOutput("midreset_ferr", 32'(rx_frame_error), 32'h0);
        checkOutput("midreset_busy", 32'(rx_busy), 32'h0);
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        sendLevel(1'b1, 10);
        applyStimulus(8'h42, 1'b1, BIT_CYCLES, 20);
        compareEvents("after_reset");
        checkOutput("after_reset_valid_count", 32'(valid_count), 32'd1);
        checkOutput("after_reset_error_count", 32'(error_count), 32'd0);
        checkOutput("after_reset_data", 32'(rx_data), 32'h42);

        // Transmitter-style stream: fixed patterns, then random bytes and stops.
        clearMonitor();
        fixed_bytes[0] = 8'h00;
        fixed_bytes[1] = 8'h55;
        fixed_bytes[2] = 8'hAA;
        fixed_bytes[3] = 8'hFF;
        for (int i = 0; i < 4; i++)
            applyStimulus(fixed_bytes[i], 1'b1, BIT_CYCLES, $urandom_range(0, 8));
        for (int i = 0; i < 12; i++) begin
            rnd  = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            if (good) applyStimulus(rnd, 1'b1, BIT_CYCLES, $urandom_range(0, 10));
            else      applyStimulus(rnd, 1'b0, BIT_CYCLES, $urandom_range(2, 10));
        end
        repeat (40) @(negedge clock);
        compareEvents("stream");
        checkOutput("stream_final_data", 32'(rx_data), 32'(last_good));
        checkOutput("never_valid_and_error", 32'(both_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first; the receive-side counterpart of the team's uart_tx.
- Synchronizes the asynchronous serial line and qualifies the start bit at mid-bit.
- Samples each data bit at its centre and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- BAUDRATE, 56600, serial bit rate in bits/s; must match the paired uart_tx.
- HZ, 100_000_000, i_clock frequency in Hz.
- DIVIDER (localparam), HZ/BAUDRATE (integer division, truncating), clock cycles per bit; 1766 at defaults.
- HALF (localparam), DIVIDER/2, clock cycles to start-bit centre; 883 at defaults.
- COUNTER_WIDTH (localparam), $clog2(DIVIDER); the bit counter is COUNTER_WIDTH+1 bits wide.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_signal  input  1  serial line, idle high, asynchronous to i_clock.
- o_data  output  8  last correctly framed byte; holds until the next good byte.
- o_valid  output  1  one-cycle pulse: o_data updated this cycle.
- o_frame_error  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, i_reset_n=0) forces all state, with no clock required:
  - o_data=0, o_valid=0, o_frame_error=0, o_busy=0.
  - FSM=IDLE, counter=0, bit index=0, shift register=0.
  - Both synchronizer flops and the edge-detect flop = 1 (idle line).
  - Reset mid-frame discards the partial byte; no pulse is emitted.
- Synchronizer: 2-flop chain on i_signal gives rx_s. rx_s is registered once more as rx_d for falling-edge detection.
- The counter counts 0..limit then clears. There are no comparisons against values greater than DIVIDER-1.
- FSM:
  - IDLE: on rx_d=1 and rx_s=0, go to START with counter=0.
  - START: when counter==HALF-1, sample rx_s. If 0, go to DATA with counter=0 and bit index=0. If 1, the glitch is rejected: go to IDLE with no output.
  - DATA: when counter==DIVIDER-1, clear counter and shift rx_s into the shift register MSB, shifting right. After the 8th sample (bit index 7), go to STOP.
  - STOP: when counter==DIVIDER-1, sample rx_s.
    - If 1: o_data<=shift register, o_valid=1 for exactly one cycle, go to IDLE.
    - If 0: o_frame_error=1 for exactly one cycle, o_data unchanged, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line (break) produces exactly one frame error, not repeated frames.
- Sampling points fall at bit centres: HALF + k*DIVIDER cycles after the detected edge.
- Latency: o_valid asserts HALF + 9*DIVIDER + 3 cycles after the i_signal falling edge, ±1 cycle for synchronizer phase.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. A start edge immediately after a 1-bit stop is therefore caught. No idle gap is required between frames.
- o_valid and o_frame_error are never high in the same cycle.
- o_valid is not gated by a consumer: there is no backpressure. A consumer missing the pulse loses the byte.
- o_busy = (FSM != IDLE). It is registered from the state and goes low in the same cycle that o_valid pulses.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK; 3 bits).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Divider computation shared with uart_tx.
- Sub-module uart_sync: 2-flop synchronizer with parameterizable reset value (1 here). It is reusable for other asynchronous inputs.

Test Plan:
- HZ=16, BAUDRATE=1 (DIVIDER=16, HALF=8). Drive frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1), 16 cycles/bit -> one o_valid pulse, o_data=0xA5, o_frame_error never high, o_busy high for the whole frame.
- Same config, line low for 3 cycles then high -> FSM returns to IDLE, no o_valid, no o_frame_error, o_busy high at most 8 cycles.
- Frame 0x3C with stop bit driven low and the line held low 40 cycles -> exactly one o_frame_error pulse, o_valid never high, o_data still holds the previous byte. o_busy drops only after the line returns high.
- Back-to-back 0x00 then 0xFF, 1 stop bit, no gap -> two o_valid pulses 160 cycles apart, o_data=0x00 then 0xFF.
- Assert i_reset_n=0 during data bit 4 of 0x81, release, then send 0x42 -> no pulse for the aborted frame, outputs 0 during reset, one o_valid with o_data=0x42.
- Loopback with uart_tx at default parameters: send 0x00, 0x55, 0xAA, 0xFF -> four o_valid pulses with matching o_data, no framing errors.
